// File: rtl/button_conditioner.sv
// Purpose : turns a raw, bouncy, asynchronous push-button into a debounced level and a clean one-cycle press pulse.
// Latency : a clean raw change settled before edge 0 shows on button_level/button_pulse after edge DEBOUNCE_CYCLES+1.
// Backpres: none; the output pulse is fire-and-forget.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   button_raw   raw button level (asynchronous, may bounce)
//   button_level debounced, synchronised level
//   button_pulse one-cycle press pulse (feeds the LED block's `button`)
//
// Optional feature macro: BUTTON_AUTO_REPEAT_EN adds hold/auto-repeat pulses while the button stays pressed.
// Without it, HOLD_CYCLES and REPEAT_CYCLES have no effect and a held button gives exactly one pulse.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int REPEAT_CYCLES   = 8,
    parameter int CNT_WIDTH       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic button_level,
    output logic button_pulse
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Two-flop synchroniser; only sync2_q is visible to the debouncer.
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= button_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive samples that disagree with the current level.
    logic                 level_q, level_d;
    logic [CNT_WIDTH-1:0] db_cnt_q, db_cnt_d;
    logic                 rise, fall;

    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        rise     = 1'b0;
        fall     = 1'b0;
        if (sync2_q != level_q) begin
            if (db_cnt_q >= DB_LAST) begin
                level_d  = sync2_q;
                db_cnt_d = '0;
                rise     = sync2_q;
                fall     = ~sync2_q;
            end else if (db_cnt_q != CNT_MAX) begin
                db_cnt_d = db_cnt_q + 1'b1;
            end else begin
                db_cnt_d = db_cnt_q;
            end
        end
    end

    logic pulse_q, pulse_d;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] rpt_cnt_q, rpt_cnt_d;

    // rpt_cnt_q equals the number of cycles since the last emitted pulse,
    // so the press pulse cycle is count 0.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        pulse_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rpt_cnt_d = '0;
                if (rise) begin
                    state_d = ST_HOLD;
                    pulse_d = 1'b1;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                // A release wins over a repeat that falls due on the same edge.
                if (fall) begin
                    state_d   = ST_IDLE;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q >= ((state_q == ST_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
                    state_d   = ST_REPEAT;
                    rpt_cnt_d = '0;
                    pulse_d   = 1'b1;
                end else if (rpt_cnt_q != CNT_MAX) begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                rpt_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESSED = 1'b1;

    logic [0:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PRESSED;
                    pulse_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Hold/repeat timing only matters with auto-repeat; fold the values away here.
    logic unused_cfg;
    assign unused_cfg = ^{CNT_WIDTH'(HOLD_CYCLES), CNT_WIDTH'(REPEAT_CYCLES)};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q  <= 1'b0;
            db_cnt_q <= '0;
            pulse_q  <= 1'b0;
            state_q  <= ST_IDLE;
        end else begin
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
            pulse_q  <= pulse_d;
            state_q  <= state_d;
        end
    end

    assign button_level = level_q;
    assign button_pulse = pulse_q;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream stage of the dynamic LED colour block. Conditions a raw, bouncy, asynchronous push-button into a clean single-cycle pulse that drives the LED block's `button` input, so `colour` advances exactly once per physical press.
- Pipeline: 2-FF synchroniser, then debounce counter, then press/auto-repeat FSM.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a level change (must be >= 1).
- HOLD_CYCLES, 16, cycles from the press pulse to the first auto-repeat pulse (used only with the optional feature).
- REPEAT_CYCLES, 8, cycles between subsequent auto-repeat pulses (used only with the optional feature).
- CNT_WIDTH, 16, width of the internal counters; all cycle parameters must fit in it.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- button_raw  input  1  raw push-button level, asynchronous to clk, may bounce.
- button_level  output  1  debounced, synchronised button level.
- button_pulse  output  1  one-cycle press pulse; connects to the LED block's `button`.

Behaviour:
- Reset (rst=0, asynchronous):
  - Clears sync1, sync2, button_level, button_pulse, all counters; FSM goes to IDLE.
  - The block is held in reset while rst=0; normal operation resumes on the first rising edge with rst=1.
- Synchroniser: sync1 <= button_raw; sync2 <= sync1. sync2 is the only signal the debouncer sees.
- Debounce, on each edge:
  - If sync2 != button_level and cnt == DEBOUNCE_CYCLES-1: button_level <= sync2, cnt <= 0.
  - Else if sync2 != button_level: cnt <= cnt+1.
  - Else: cnt <= 0. Any bounce back to the current level restarts the count.
- Latency: a clean raw change stable before edge 0 updates button_level after edge DEBOUNCE_CYCLES+1.
- button_pulse is registered and high for exactly one cycle, coincident with the first cycle that button_level=1 after a 0->1 change. No pulse on release.
- FSM states IDLE, PRESSED:
  - IDLE -> PRESSED on accepted rise, emitting a pulse.
  - PRESSED -> IDLE on accepted fall.
- Boundaries:
  - Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no level change and no pulse.
  - A release and re-press each need full debounce, so the minimum pulse spacing is 2*DEBOUNCE_CYCLES cycles.
  - Reset asserted mid-count or mid-hold discards all progress; button_pulse drops immediately.
  - Counters saturate and never wrap.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- When defined, the FSM has states IDLE, HOLD, REPEAT:
  - On the press pulse: enter HOLD, clear rpt_cnt.
  - In HOLD: after HOLD_CYCLES cycles with the pulse counted as cycle 0, emit a one-cycle pulse and enter REPEAT.
  - In REPEAT: emit a pulse every REPEAT_CYCLES cycles.
  - An accepted fall in any state returns to IDLE on that edge with no pulse. A fall coinciding with a due repeat pulse suppresses that pulse.
- When undefined: two-state FSM as above; holding the button yields exactly one pulse; HOLD_CYCLES and REPEAT_CYCLES are ignored.

Test Plan:
- Reset: rst=0 for 2 cycles with button_raw=1 -> button_level=0, button_pulse=0 throughout; after release, the press is accepted only after 6 clean edges.
- Clean press, DEBOUNCE_CYCLES=4: raw 0->1 before edge 0, held for 20 cycles -> button_level rises after edge 5, button_pulse high only in that cycle; LED colour goes 1->2 exactly once.
- Bounce: raw toggles 1,0,1,0,1 with 2-cycle segments, then stays 1 -> no pulse during the bounce; a single pulse 6 edges after the final rise.
- Glitch: raw high for 3 cycles, then 0 -> button_level stays 0, no pulse.
- Reset mid-operation: rst=0 at cnt=2 during a press -> cnt, level and pulse cleared; re-press requires a full 6-edge latency.
- BUTTON_AUTO_REPEAT_EN defined, HOLD=16, REPEAT=8, held for 40 cycles after the press pulse -> pulses at offsets 0, 16, 24, 32, 40; release -> no further pulses. Without the macro: one pulse only.
